// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word-addressed memory reads, keeps returned words in an
// in-order prefetch queue, and hands them to the decoder; a redirect flushes and restarts fetch.
module instr_fetch #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'd1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pointer
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + PW + 1;
   localparam logic [PW:0]   DEPTH_C  = (PW+1)'(DEPTH);
   localparam logic [CW-1:0] DROP_MAX = '1;

   logic [31:0]    fp_q, fp_d;
   logic [PW-1:0]  alloc_q, alloc_d;
   logic [PW-1:0]  fill_q, fill_d;
   logic [PW-1:0]  head_q, head_d;
   logic [PW:0]    occ_q, occ_d;
   logic [PW:0]    pend_q, pend_d;
   logic [CW-1:0]  drop_q, drop_d;
   logic [DEPTH-1:0] filled_q, filled_d;
   logic [31:0]    addr_q [DEPTH];
   logic [31:0]    data_q [DEPTH];

   logic req_hs;
   logic pop;
   logic rsp_drop;
   logic rsp_fill;

   // Responses still owed by memory after a flush: the old discard backlog plus every
   // allocated-but-unfilled slot, less one if a response lands in the redirect cycle itself.
   function automatic logic [CW-1:0] drop_after_redirect(input logic [CW-1:0] drop,
                                                         input logic [PW:0]   pend,
                                                         input logic          rsp);
      logic [SW-1:0] sum;
      sum = SW'(drop) + SW'(pend);
      if (rsp && (sum != '0)) sum = sum - SW'(1);
      if (sum > SW'(DROP_MAX)) return DROP_MAX;
      return sum[CW-1:0];
   endfunction

   assign mem_req_valid = !reset && !redirect_valid && (occ_q != DEPTH_C);
   assign mem_req_addr  = fp_q;
   assign req_hs        = mem_req_valid && mem_req_ready;

   assign instr_valid   = filled_q[head_q];
   assign instruction   = instr_valid ? data_q[head_q] : '0;
   assign instr_pointer = instr_valid ? addr_q[head_q] : '0;
   assign pop           = instr_valid && instr_ready;

   assign rsp_drop = mem_rsp_valid && (drop_q != '0);
   assign rsp_fill = mem_rsp_valid && (drop_q == '0) && (pend_q != '0);

   always_comb begin
      fp_d     = fp_q;
      alloc_d  = alloc_q;
      fill_d   = fill_q;
      head_d   = head_q;
      occ_d    = occ_q;
      pend_d   = pend_q;
      drop_d   = drop_q;
      filled_d = filled_q;
      if (redirect_valid) begin
         fp_d     = redirect_addr;
         alloc_d  = '0;
         fill_d   = '0;
         head_d   = '0;
         occ_d    = '0;
         pend_d   = '0;
         filled_d = '0;
         drop_d   = drop_after_redirect(drop_q, pend_q, mem_rsp_valid);
      end else begin
         if (req_hs) begin
            alloc_d = alloc_q + PW'(1);
            fp_d    = fp_q + 32'd1;
         end
         if (rsp_drop) begin
            drop_d = drop_q - CW'(1);
         end
         if (rsp_fill) begin
            filled_d[fill_q] = 1'b1;
            fill_d           = fill_q + PW'(1);
         end
         if (pop) begin
            filled_d[head_q] = 1'b0;
            head_d           = head_q + PW'(1);
         end
         occ_d  = occ_q + (PW+1)'(req_hs) - (PW+1)'(pop);
         pend_d = pend_q + (PW+1)'(req_hs) - (PW+1)'(rsp_fill);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fp_q     <= RESET_ADDR;
         alloc_q  <= '0;
         fill_q   <= '0;
         head_q   <= '0;
         occ_q    <= '0;
         pend_q   <= '0;
         drop_q   <= '0;
         filled_q <= '0;
      end else begin
         fp_q     <= fp_d;
         alloc_q  <= alloc_d;
         fill_q   <= fill_d;
         head_q   <= head_d;
         occ_q    <= occ_d;
         pend_q   <= pend_d;
         drop_q   <= drop_d;
         filled_q <= filled_d;
      end
   end

   // Slot payload carries no reset; the filled flags alone decide what is visible.
   always_ff @(posedge clk) begin
      if (req_hs) begin
         addr_q[alloc_q] <= fp_q;
      end
      if (rsp_fill && !redirect_valid) begin
         data_q[fill_q] <= mem_rsp_data;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a queue-based memory model with selectable latency
// returns addr ^ A5A5_0000, and each step checks hand-derived outputs.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] instr_pointer;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   int cyc = 0;
   int lat = 1;
   int req_cnt = 0;
   logic [31:0] rq_addr [$];
   int          rq_due  [$];
   logic [31:0] req_log [$];
   logic [31:0] dlv_a   [$];
   logic [31:0] dlv_d   [$];

   always #5 clk = ~clk;

   instr_fetch #(.DEPTH(4), .RESET_ADDR(32'd1)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instruction    (instruction),
      .instr_pointer  (instr_pointer)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] dlv_addr(input int i);
      if (i < dlv_a.size()) return dlv_a[i];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] dlv_data(input int i);
      if (i < dlv_d.size()) return dlv_d[i];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] req_at(input int i);
      if (i < req_log.size()) return req_log[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample pre-edge handshakes, then update the memory model for the new cycle.
   task automatic tick();
      logic        hs, pp, rs;
      logic [31:0] ha, pa, pd;
      #1;
      hs = mem_req_valid && mem_req_ready;
      ha = mem_req_addr;
      pp = instr_valid && instr_ready;
      pa = instr_pointer;
      pd = instruction;
      rs = reset;
      @(posedge clk);
      cyc++;
      #1;
      if (hs) begin
         req_cnt++;
         req_log.push_back(ha);
         rq_addr.push_back(ha);
         rq_due.push_back(cyc - 1 + lat);
      end
      if (pp) begin
         dlv_a.push_back(pa);
         dlv_d.push_back(pd);
      end
      if (rs) begin
         rq_addr.delete();
         rq_due.delete();
      end
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = mem_word(rq_addr[0]);
         void'(rq_addr.pop_front());
         void'(rq_due.pop_front());
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = '0;
      end
      #1;
   endtask

   initial begin
      reset          = 1'b1;
      mem_req_ready  = 1'b1;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      instr_ready    = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_instruction", instruction, 0);
      check("rst_pointer", instr_pointer, 0);

      // Stream with 1-cycle memory
      reset = 1'b0;
      #1;
      check("first_req_valid", mem_req_valid, 1);
      check("first_req_addr", mem_req_addr, 32'd1);
      tick();
      check("lat_c1_invalid", instr_valid, 0);
      tick();
      for (int k = 0; k < 6; k++) begin
         check("stream_valid", instr_valid, 1);
         check("stream_ptr", instr_pointer, 32'd1 + k);
         check("stream_data", instruction, mem_word(32'd1 + k));
         tick();
      end

      // Reset mid-stream with the queue partly occupied
      reset = 1'b1;
      tick();
      check("midrst_instr_valid", instr_valid, 0);
      check("midrst_req_valid", mem_req_valid, 0);
      reset = 1'b0;
      instr_ready = 1'b0;
      #1;
      check("restart_req_valid", mem_req_valid, 1);
      check("restart_req_addr", mem_req_addr, 32'd1);

      // Backpressure until full
      req_cnt = 0;
      req_log.delete();
      repeat (3) tick();
      check("bp_hold_valid_early", instr_valid, 1);
      check("bp_hold_ptr_early", instr_pointer, 32'd1);
      repeat (7) tick();
      check("bp_req_count", req_cnt, 4);
      check("bp_req0", req_at(0), 32'd1);
      check("bp_req3", req_at(3), 32'd4);
      check("bp_full_req_valid", mem_req_valid, 0);
      check("bp_hold_valid", instr_valid, 1);
      check("bp_hold_ptr", instr_pointer, 32'd1);
      check("bp_hold_data", instruction, mem_word(32'd1));

      instr_ready = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         check("bp_drain_valid", instr_valid, 1);
         check("bp_drain_ptr", instr_pointer, 32'd1 + k);
         if (k == 1) begin
            check("bp_resume_valid", mem_req_valid, 1);
            check("bp_resume_addr", mem_req_addr, 32'd5);
         end
         tick();
      end

      // Drain, then redirect with two requests in flight on a 3-cycle memory
      mem_req_ready = 1'b0;
      repeat (4) tick();
      check("drained_invalid", instr_valid, 0);
      lat = 3;
      mem_req_ready = 1'b1;
      #1;
      check("pre_redir_addr", mem_req_addr, 32'd10);
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_addr  = 32'h100;
      #1;
      check("redir_req_blocked", mem_req_valid, 0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("redir_r1_invalid", instr_valid, 0);
      check("redir_r1_req_valid", mem_req_valid, 1);
      check("redir_r1_req_addr", mem_req_addr, 32'h100);
      dlv_a.delete();
      dlv_d.delete();
      repeat (10) tick();
      check("redir_dlv0_addr", dlv_addr(0), 32'h100);
      check("redir_dlv0_data", dlv_data(0), mem_word(32'h100));
      check("redir_dlv1_addr", dlv_addr(1), 32'h101);
      check("redir_dlv1_data", dlv_data(1), mem_word(32'h101));

      // Redirect coinciding with a response, a decoder handshake and mem_req_ready
      mem_req_ready = 1'b0;
      repeat (8) tick();
      lat = 1;
      mem_req_ready = 1'b1;
      repeat (4) tick();
      redirect_valid = 1'b1;
      redirect_addr  = 32'h200;
      #1;
      check("simul_req_blocked", mem_req_valid, 0);
      check("simul_instr_valid", instr_valid, 1);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("simul_r1_invalid", instr_valid, 0);
      check("simul_r1_req_valid", mem_req_valid, 1);
      check("simul_r1_req_addr", mem_req_addr, 32'h200);
      dlv_a.delete();
      dlv_d.delete();
      repeat (6) tick();
      check("simul_dlv0_addr", dlv_addr(0), 32'h200);
      check("simul_dlv0_data", dlv_data(0), mem_word(32'h200));
      check("simul_dlv1_addr", dlv_addr(1), 32'h201);

      // Address wrap past 32'hFFFF_FFFF
      redirect_valid = 1'b1;
      redirect_addr  = 32'hFFFF_FFFF;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("wrap_req_addr", mem_req_addr, 32'hFFFF_FFFF);
      dlv_a.delete();
      dlv_d.delete();
      repeat (8) tick();
      check("wrap_dlv0_addr", dlv_addr(0), 32'hFFFF_FFFF);
      check("wrap_dlv0_data", dlv_data(0), mem_word(32'hFFFF_FFFF));
      check("wrap_dlv1_addr", dlv_addr(1), 32'h0);
      check("wrap_dlv2_addr", dlv_addr(2), 32'h1);
      check("wrap_dlv2_data", dlv_data(2), mem_word(32'h1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
